// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Holds one LANES x ROWS matrix of complex samples ({real, imag}) in
//   per-lane banks. On start it streams the matrix into the PE array with a
//   diagonal skew, so lane i carries row t-k at beat t, where k = i (dir=0)
//   or LANES-1-i (dir=1). Lanes outside the live diagonal carry zero with
//   their lane-valid flag low. The output is a valid/ready stream.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   wr_en/lane/row/data sample load, honoured only while idle
//   start, dir         begin streaming; dir is latched on start
//   out_ready          array accepts the current beat
//   out_valid          out_data/out_lane_vld hold a beat
//   out_data           lane i at [2*DW*i +: 2*DW]
//   out_lane_vld       per-lane sample-present flag
//   busy               stream in progress
//   done               one-cycle pulse after the final beat is accepted

// One lane: a ROWS-deep bank with a synchronous read port whose output
// register doubles as this lane's slice of the output beat.
module systolic_skew_feeder_lane #(
  parameter int LANES = 8,
  parameter int ROWS  = 64,
  parameter int DW    = 16,
  parameter int IDX   = 0,
  parameter int LW    = 3,
  parameter int RW    = 6,
  parameter int TW    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ok,
  input  logic [LW-1:0]   wr_lane,
  input  logic [RW-1:0]   wr_row,
  input  logic [2*DW-1:0] wr_data,
  input  logic            rd_en,
  input  logic            dir,
  input  logic [TW-1:0]   t,
  output logic [2*DW-1:0] lane_data,
  output logic            lane_vld
);
  localparam int KR = LANES - 1 - IDX;
  localparam logic [LW-1:0] MY_LANE = IDX[LW-1:0];
  localparam logic [TW:0]   K_FWD   = IDX[TW:0];
  localparam logic [TW:0]   K_REV   = KR[TW:0];
  localparam logic [TW-1:0] ROWS_T  = ROWS[TW-1:0];

  logic [2*DW-1:0] mem [ROWS];
  logic [TW:0]     diff;
  logic            in_rng;
  logic [RW-1:0]   addr;
  logic            row_ok;

  // When ROWS is a power of two every row address is legal.
  generate
    if ((1 << RW) == ROWS) begin : g_row_full
      assign row_ok = 1'b1;
    end else begin : g_row_chk
      localparam logic [RW-1:0] ROWS_R = ROWS[RW-1:0];
      assign row_ok = (wr_row < ROWS_R);
    end
  endgenerate

  // Row for this beat is t-k; a borrow out of the subtract means the
  // diagonal has not reached this lane yet.
  always_comb begin
    diff   = {1'b0, t} - (dir ? K_REV : K_FWD);
    in_rng = !diff[TW] && (diff[TW-1:0] < ROWS_T);
    addr   = diff[RW-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_ok && (wr_lane == MY_LANE) && row_ok)
      mem[wr_row] <= wr_data;
  end

  // Read register only moves on an advance, so a stalled beat stays put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_data <= '0;
      lane_vld  <= 1'b0;
    end else if (rd_en) begin
      lane_vld  <= in_rng;
      lane_data <= in_rng ? mem[addr] : '0;
    end
  end
endmodule

module systolic_skew_feeder #(
  parameter  int LANES = 8,
  parameter  int ROWS  = 64,
  parameter  int DW    = 16,
  localparam int LW    = $clog2(LANES),
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int TW    = $clog2(ROWS + LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [LW-1:0]         wr_lane,
  input  logic [RW-1:0]         wr_row,
  input  logic [2*DW-1:0]       wr_data,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [LANES*2*DW-1:0] out_data,
  output logic [LANES-1:0]      out_lane_vld,
  output logic                  busy,
  output logic                  done
);
  localparam int LAST_I = ROWS + LANES - 2;
  localparam logic [TW-1:0] T_LAST = LAST_I[TW-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                        state;
  logic [TW-1:0]                 t;
  logic                          dir_q;
  logic                          adv;
  logic                          rd_en;
  logic                          wr_ok;
  logic [LANES-1:0][2*DW-1:0]    lane_data;

  // A beat moves when the output slot is empty or being taken this cycle.
  assign adv   = !out_valid || out_ready;
  assign rd_en = (state == RUN) && adv;
  assign wr_ok = wr_en && (state == IDLE);

  assign out_data = lane_data;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      systolic_skew_feeder_lane #(
        .LANES(LANES), .ROWS(ROWS), .DW(DW), .IDX(i),
        .LW(LW), .RW(RW), .TW(TW)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .wr_ok    (wr_ok),
        .wr_lane  (wr_lane),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .dir      (dir_q),
        .t        (t),
        .lane_data(lane_data[i]),
        .lane_vld (out_lane_vld[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      t         <= '0;
      dir_q     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            t     <= '0;
            dir_q <= dir;
          end
        end
        RUN: begin
          if (adv) begin
            out_valid <= 1'b1;
            if (t == T_LAST) state <= DRAIN;
            else             t     <= t + 1'b1;
          end
        end
        DRAIN: begin
          // out_valid is always high here: the last beat is waiting.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            t         <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int L = 8, R = 64, DW = 16, SW = 32, NB = R + L - 1;
  localparam int L2 = 4, R2 = 3, DW2 = 8, SW2 = 16, NB2 = L2 + R2 - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Main instance (8 x 64)
  logic         wr_en, start, dir, out_ready;
  logic [2:0]   wr_lane;
  logic [5:0]   wr_row;
  logic [31:0]  wr_data;
  logic         out_valid, busy, done;
  logic [255:0] out_data;
  logic [7:0]   out_lane_vld;

  // Small instance (4 x 3)
  logic         b_wr_en, b_start, b_dir, b_ready;
  logic [1:0]   b_wr_lane, b_wr_row;
  logic [15:0]  b_wr_data;
  logic         b_valid, b_busy, b_done;
  logic [63:0]  b_data;
  logic [3:0]   b_vld;

  systolic_skew_feeder #(.LANES(L), .ROWS(R), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_lane(wr_lane), .wr_row(wr_row),
    .wr_data(wr_data), .start(start), .dir(dir), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_lane_vld(out_lane_vld),
    .busy(busy), .done(done));

  systolic_skew_feeder #(.LANES(L2), .ROWS(R2), .DW(DW2)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_lane(b_wr_lane), .wr_row(b_wr_row),
    .wr_data(b_wr_data), .start(b_start), .dir(b_dir), .out_ready(b_ready),
    .out_valid(b_valid), .out_data(b_data), .out_lane_vld(b_vld),
    .busy(b_busy), .done(b_done));

  typedef struct {logic [255:0] d; logic [7:0] v;} beat_t;

  int total = 0, bad = 0;
  logic [31:0] mdl [L][R];
  logic [15:0] mdl_b [L2][R2];
  beat_t exp_q[$], cap_q[$], ref_q[$];
  logic [67:0] b_cap[$];
  int done_cnt = 0, beats = 0;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: lane i at beat t shows row t-k, k = i or L-1-i.
  task automatic push_stream(input logic d);
    for (int t = 0; t < NB; t++) begin
      beat_t b;
      b.d = '0; b.v = '0;
      for (int i = 0; i < L; i++) begin
        int k, r;
        k = d ? (L - 1 - i) : i;
        r = t - k;
        if (r >= 0 && r < R) begin
          b.d[SW*i +: SW] = mdl[i][r];
          b.v[i] = 1'b1;
        end
      end
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard monitor
  logic         stall_q = 1'b0;
  logic [255:0] stall_d;
  logic [7:0]   stall_v;
  beat_t        mon_e, mon_c;
  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 256'(out_valid), 256'(1));
        chk("stall_data", out_data, stall_d);
        chk("stall_vld", 256'(out_lane_vld), 256'(stall_v));
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_beat act=%h exp=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", out_data, mon_e.d);
          chk("beat_vld", 256'(out_lane_vld), 256'(mon_e.v));
        end
        mon_c.d = out_data; mon_c.v = out_lane_vld;
        cap_q.push_back(mon_c);
      end
      stall_q = out_valid && !out_ready;
      stall_d = out_data;
      stall_v = out_lane_vld;
      if (done) done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst && b_valid && b_ready) b_cap.push_back({b_vld, b_data});
  end

  task automatic wr(input int ln, input int rw, input logic [31:0] d);
    wr_en = 1'b1; wr_lane = 3'(ln); wr_row = 6'(rw); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_stream(input logic d, input bit rnd, input bit inject,
                            input int abort_at, input bit same_wr, output int cyc);
    int b0;
    bit aborted;
    logic [31:0] nv;
    b0 = beats; aborted = 0;
    if (same_wr) begin
      nv = $urandom;
      wr_en = 1'b1; wr_lane = 3'd0; wr_row = 6'd0; wr_data = nv;
      mdl[0][0] = nv;
    end
    push_stream(d);
    out_ready = 1'b1;
    dir = d; start = 1'b1;
    tick();
    start = 1'b0; dir = 1'b0; wr_en = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (!rnd && cyc == 0) begin
        chk("busy_at_c1", 256'(busy), 256'(1));
        chk("valid_low_c1", 256'(out_valid), 256'(0));
      end
      if (!rnd && cyc == 1) chk("valid_at_c2", 256'(out_valid), 256'(1));
      if (inject && cyc == 10) begin
        start = 1'b1; wr_en = 1'b1; wr_lane = 3'd2; wr_row = 6'd5; wr_data = 32'hdead_beef;
      end
      if (inject && cyc == 11) begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (abort_at > 0 && beats - b0 >= abort_at) begin
        rst = 1'b0;
        #1;
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_vld", 256'(out_lane_vld), 256'(0));
        chk("rst_data", out_data, 256'(0));
        aborted = 1;
        break;
      end
      if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    if (!aborted) begin
      if (cyc >= 3000) begin
        total++; bad++;
        $display("FAIL done_timeout act=%0d exp<3000", cyc);
      end
      chk("busy_fall_with_done", 256'(busy), 256'(0));
      chk("all_beats_seen", 256'(exp_q.size()), 256'(0));
    end
  endtask

  initial begin
    int cyc, dc;
    logic [3:0] bv [NB2];
    bv = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    rst = 1'b0;
    wr_en = 0; start = 0; dir = 0; out_ready = 1; wr_lane = 0; wr_row = 0; wr_data = 0;
    b_wr_en = 0; b_start = 0; b_dir = 0; b_ready = 1; b_wr_lane = 0; b_wr_row = 0; b_wr_data = 0;
    tick(); tick();
    chk("reset_valid", 256'(out_valid), 256'(0));
    chk("reset_data", out_data, 256'(0));
    chk("reset_vld", 256'(out_lane_vld), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_done", 256'(done), 256'(0));
    chk("reset_b_valid", 256'(b_valid), 256'(0));
    rst = 1'b1;
    tick();

    // Bank i row r = {r, i}
    for (int i = 0; i < L; i++)
      for (int r = 0; r < R; r++) begin
        mdl[i][r] = {16'(r), 16'(i)};
        wr(i, r, mdl[i][r]);
      end

    // dir=0 back-to-back
    cap_q.delete();
    run_stream(1'b0, 0, 0, 0, 0, cyc);
    chk("done_latency", 256'(cyc), 256'(NB + 1));
    chk("beat_count", 256'(cap_q.size()), 256'(NB));
    if (cap_q.size() == NB) begin
      chk("b0_vld", 256'(cap_q[0].v), 256'(8'h01));
      chk("b0_data", cap_q[0].d, 256'(0));
      chk("b7_vld", 256'(cap_q[7].v), 256'(8'hff));
      chk("b7_lane3", 256'(cap_q[7].d[3*SW +: SW]), 256'(32'h0004_0003));
      chk("b70_vld", 256'(cap_q[70].v), 256'(8'h80));
      chk("b70_lane7", 256'(cap_q[70].d[7*SW +: SW]), 256'(32'h003f_0007));
    end
    ref_q = cap_q;
    tick();
    chk("done_is_pulse", 256'(done), 256'(0));

    // dir=1
    cap_q.delete();
    run_stream(1'b1, 0, 0, 0, 0, cyc);
    if (cap_q.size() == NB) begin
      chk("d1_b0_vld", 256'(cap_q[0].v), 256'(8'h80));
      chk("d1_b0_lane7", 256'(cap_q[0].d[7*SW +: SW]), 256'(32'h0000_0007));
      chk("d1_b70_vld", 256'(cap_q[70].v), 256'(8'h01));
      chk("d1_b70_lane0", 256'(cap_q[70].d[SW-1:0]), 256'(32'h003f_0000));
    end
    tick();

    // Random back-pressure must reproduce the back-to-back sequence
    cap_q.delete();
    dc = done_cnt;
    run_stream(1'b0, 1, 0, 0, 0, cyc);
    tick();
    chk("rnd_done_once", 256'(done_cnt), 256'(dc + 1));
    chk("rnd_count", 256'(cap_q.size()), 256'(NB));
    if (cap_q.size() == NB && ref_q.size() == NB)
      for (int k = 0; k < NB; k++) chk("rnd_vs_ref", cap_q[k].d, ref_q[k].d);

    // start and wr_en while running are ignored
    dc = done_cnt;
    run_stream(1'b0, 0, 1, 0, 0, cyc);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_retrigger", 256'(busy), 256'(0));
    end
    chk("inject_done_once", 256'(done_cnt), 256'(dc + 1));

    // Reset at beat 20, no done, then a clean restart
    dc = done_cnt;
    run_stream(1'b0, 0, 0, 20, 0, cyc);
    exp_q.delete();
    for (int k = 0; k < 5; k++) tick();
    chk("rst_no_done", 256'(done_cnt), 256'(dc));
    rst = 1'b1;
    tick();
    cap_q.delete();
    run_stream(1'b0, 0, 0, 0, 0, cyc);
    chk("restart_latency", 256'(cyc), 256'(NB + 1));
    if (cap_q.size() == NB && ref_q.size() == NB)
      for (int k = 0; k < NB; k++) chk("restart_vs_ref", cap_q[k].d, ref_q[k].d);
    tick();

    // Random contents, random dir, random ready, write+start together
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < L; i++)
        for (int r = 0; r < R; r++) begin
          mdl[i][r] = $urandom;
          wr(i, r, mdl[i][r]);
        end
      run_stream(1'($urandom_range(0, 1)), 1, 0, 0, 1, cyc);
      tick();
    end

    // Small instance: 4 lanes x 3 rows, bank i row r = {r, i}
    for (int i = 0; i < L2; i++)
      for (int r = 0; r < R2; r++) begin
        mdl_b[i][r] = {8'(r), 8'(i)};
        b_wr_en = 1'b1; b_wr_lane = 2'(i); b_wr_row = 2'(r); b_wr_data = mdl_b[i][r];
        tick();
      end
    // Row 3 does not exist; must be dropped
    b_wr_lane = 2'd1; b_wr_row = 2'd3; b_wr_data = 16'hffff;
    tick();
    b_wr_en = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 100) begin tick(); cyc++; end
    chk("b_done_latency", 256'(cyc), 256'(NB2 + 1));
    chk("b_count", 256'(b_cap.size()), 256'(NB2));
    if (b_cap.size() == NB2)
      for (int t = 0; t < NB2; t++) begin
        logic [63:0] ed;
        ed = '0;
        for (int i = 0; i < L2; i++)
          if (t - i >= 0 && t - i < R2) ed[SW2*i +: SW2] = mdl_b[i][t-i];
        chk("b_vld", 256'(b_cap[t][67:64]), 256'(bv[t]));
        chk("b_data", 256'(b_cap[t][63:0]), 256'(ed));
      end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Parametrised operand feeder for the complex-valued PE array. Holds one LANES x ROWS matrix of complex samples in per-lane banks, then streams it into the array one beat per cycle with diagonal skew and zero padding, so lane i receives row t-i at beat t. Adds valid/ready back-pressure, a selectable skew direction and a done pulse, so the array no longer needs a free-running bench-side feeder.

## Interface
- LANES, 8, number of array input lanes (>=2)
- ROWS, 64, matrix rows per lane (>=1)
- DW, 16, width of each real/imag part; one sample is 2*DW bits
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  load strobe for one sample
- wr_lane  in  clog2(LANES)  target lane/bank
- wr_row  in  clog2(ROWS)  target row
- wr_data  in  2*DW  sample, {real, imag}, real in upper DW bits
- start  in  1  begin streaming; single-cycle pulse
- dir  in  1  skew direction, sampled on start: 0 = lane 0 leads, 1 = lane LANES-1 leads
- out_ready  in  1  array accepts current beat
- out_valid  out  1  out_data/out_lane_vld hold a beat
- out_data  out  LANES*2*DW  lane i at bits [2*DW*i +: 2*DW]
- out_lane_vld  out  LANES  per-lane sample-present flag
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- Storage: LANES banks, each ROWS x 2*DW, one synchronous read port (1-cycle latency) per bank plus shared write port. Contents not cleared by reset.
- Load: wr_en in IDLE writes wr_data to bank wr_lane, row wr_row. wr_en while busy ignored. Out-of-range wr_lane/wr_row ignored.
- FSM: IDLE -> RUN on start (IDLE only); RUN -> DRAIN when last beat issued to RAMs; DRAIN -> IDLE when last beat accepted (out_valid & out_ready), done pulsed in that transition's following cycle. start in RUN/DRAIN ignored.
- Beat counter t: 0 .. ROWS+LANES-2, total ROWS+LANES-1 beats; width clog2(ROWS+LANES).
- Lane index k = i (dir=0) or LANES-1-i (dir=1). Lane i at beat t carries row r = t-k if 0 <= r < ROWS, with out_lane_vld[i]=1; otherwise lane data all-zero and out_lane_vld[i]=0.
- Advance condition: adv = !out_valid | out_ready. t increments and RAM reads issue only on adv; RAM output held when not advancing. No beat dropped or duplicated under any out_ready pattern.
- Data passes through unmodified; no arithmetic on samples.

## Timing
- Reset values: out_valid 0, out_data 0, out_lane_vld 0, busy 0, done 0, FSM IDLE, t 0.
- start in cycle C: busy high from C+1; beat 0 read issued C+1; out_valid high from C+2 (latency 2).
- out_ready held high: beats on consecutive cycles C+2 .. C+2+ROWS+LANES-2; done high exactly one cycle after last accepted beat; busy falls same cycle done rises.
- out_valid high and out_ready low: out_data, out_lane_vld, out_valid stable until accepted.
- Reset asserted mid-stream: outputs return to reset values immediately (async); no done pulse; next start restarts from beat 0.
- start and wr_en in same IDLE cycle: write completes, start accepted; stream sees the new sample.
- ROWS=1: LANES beats, each exactly one lane valid.

## Test plan
- LANES=8, ROWS=64, DW=16, bank i row r = {r, i}, dir=0, out_ready=1: 71 beats; beat 0 only lane0 = {0,0}, lanes1-7 zero/vld 0; beat 7 all lanes valid, lane3 = {4,3}; beat 70 only lane7 = {63,7}; done at C+73.
- Same load, dir=1: beat 0 only lane7 valid = {0,7}; beat 70 only lane0 = {63,0}.
- out_ready toggled pseudo-randomly: captured sequence identical to back-to-back run, 71 beats, data stable while stalled.
- LANES=4, ROWS=3: 6 beats, out_lane_vld = 0001,0011,0111,1110,1100,1000.
- start and wr_en pulsed during RUN: ignored; stream and stored data unchanged; busy never re-triggered.
- rst low at beat 20: out_valid/busy 0 immediately, no done; fresh start yields full 71-beat correct stream.
